output_port_vc_arbiter: RTL
===========================

Name: output_port_vc_arbiter

Overview:
- Per-output-port scheduler for the ExaNet VC switch. Shares one output link among `input_num` input ports.
- Each input presents a request vector with one bit per (priority, VC) pair.
- Each cycle the block selects one eligible (input, VC) pair using strict priority across classes, round-robin across inputs within a class, and downstream credit availability.
- It issues a CTS, then holds the selection until the granted packet's last beat has crossed.

Parameters:
- vc_num, 3, virtual channels per priority class.
- prio_num, 2, priority classes. Higher class index = higher priority.
- input_num, 4, input ports sharing this output.
- Derived, not overridable: VCP = vc_num*prio_num. Request bit index = p*vc_num + v.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- i_request  in  [VCP-1:0] x input_num (unpacked)  per-input request vector; level-sensitive, may drop at any cycle.
- i_credit_ok  in  VCP  per-(prio,VC) downstream credit available; level.
- i_valid  in  1  data beat of the granted packet present on the output datapath.
- i_last  in  1  last beat of packet; meaningful only when i_valid=1.
- o_cts  out  1  clear-to-send pulse for the selected input.
- o_selected_input  out  clog2(input_num)  selected input index.
- o_selected_vc  out  clog2(VCP)  selected request bit index.
- o_grant  out  input_num  one-hot of the selected input while GRANT or BUSY; 0 otherwise.
- o_busy  out  1  output locked to a packet.

Behaviour:
- Reset (resetn=0 at posedge): state=IDLE; o_cts=0, o_grant=0, o_busy=0, o_selected_input=0, o_selected_vc=0; all round-robin pointers=0. Reset mid-packet drops the lock immediately, with no wait for i_last.
- Eligibility: bit (i,b) is eligible iff i_request[i][b] & i_credit_ok[b].
- Winning class: the highest p for which any input has an eligible bit in that class.
- Within the winning class:
  - The input is chosen round-robin from rr_ptr[p]: first eligible input at index >= rr_ptr[p], wrapping modulo input_num.
  - Within that input, the lowest eligible v is chosen.
- States:
  - IDLE: evaluate the arbitration combinationally. If any bit is eligible, register sel_input and sel_vc and go to GRANT at the next edge. Otherwise stay in IDLE.
  - GRANT (1 cycle):
    - o_cts = i_request[sel_input][sel_vc].
    - If that request is still high: go to BUSY and set rr_ptr[p_sel] = (sel_input+1) mod input_num, wrapping input_num-1 -> 0.
    - If it dropped: o_cts=0, return to IDLE, pointer unchanged (aborted grant).
  - BUSY:
    - o_busy=1.
    - Request deassertion and credit loss are ignored; the packet is committed.
    - On i_valid & i_last, go to IDLE at the next edge.
    - i_last without i_valid is ignored.
- Latency: a request eligible in IDLE at cycle t gives o_cts=1 at t+1.
  - A last beat in cycle t gives IDLE at t+1, and the next CTS at t+2 at the earliest.
  - Back-to-back packets therefore carry 2 cycles of overhead.
- o_selected_input and o_selected_vc are registered. They are stable from GRANT through BUSY and hold their last value in IDLE.
- o_grant is driven in GRANT and BUSY.
- Only one CTS is issued per grant.
- A single-beat packet (valid & last in the cycle after GRANT) is legal.
- Pointers are kept per priority class and are independent of one another.
- A request that rises while BUSY is not serviced until IDLE.

Test Plan:
- Single request: i_request[2]=6'b000100, all credits ok -> o_cts=1 one cycle later, sel_input=2, sel_vc=2, o_grant=4'b0100. Then i_valid&i_last -> IDLE next cycle, o_busy=0.
- Strict priority: input0 requests bit 0 (p0), input3 requests bit 4 (p1) -> input3/vc4 granted first. After its last beat, input0/vc0 gets CTS 2 cycles later.
- Round-robin: all 4 inputs hold bit 3 continuously, 1-beat packets -> grant order 0,1,2,3,0. Each CTS is 3 cycles apart.
- Credit gating: input1 requests bits 0 and 1, i_credit_ok[0]=0 -> vc1 granted. With all credits 0 -> no CTS, state stays IDLE.
- Drop at grant: input2 request present in IDLE, deasserted in the GRANT cycle -> o_cts=0, back to IDLE, rr pointer unchanged. Next grant goes to input2 if it re-requests.
- Reset mid-BUSY: assert resetn=0 during a multi-beat packet -> all outputs 0 and pointers 0 at the next edge. Then a fresh request is granted normally.

Source files
------------

// File: rtl/output_port_vc_arbiter.sv
// Per-output-port scheduler for the VC switch. It picks one (input, VC)
// pair per packet. Selection uses strict priority across classes, then
// round-robin across inputs within the winning class, then the lowest VC.
// Only pairs with downstream credit are considered.
//
// The block issues a single CTS for the winner, then locks the output until
// the packet's last beat has crossed.
//
// Handshake: a packet is granted by a one-cycle o_cts pulse in GRANT. After
// that the output stays locked (o_busy=1) until a beat with i_valid=1 and
// i_last=1 is seen. i_last is ignored when i_valid=0. While locked,
// request and credit changes are ignored.
module output_port_vc_arbiter #(
  parameter int vc_num    = 3,
  parameter int prio_num  = 2,
  parameter int input_num = 4
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic [vc_num*prio_num-1:0]            i_request [input_num],
  input  logic [vc_num*prio_num-1:0]            i_credit_ok,
  input  logic                                  i_valid,
  input  logic                                  i_last,
  output logic                                  o_cts,
  output logic [((input_num > 1) ? $clog2(input_num) : 1)-1:0] o_selected_input,
  output logic [((vc_num*prio_num > 1) ? $clog2(vc_num*prio_num) : 1)-1:0] o_selected_vc,
  output logic [input_num-1:0]                  o_grant,
  output logic                                  o_busy,
  output logic [1:0]                            o_dbg_state
);

  localparam int VCP = vc_num * prio_num;
  localparam int IW  = (input_num > 1) ? $clog2(input_num) : 1;
  localparam int VW  = (VCP > 1) ? $clog2(VCP) : 1;
  localparam int PW  = (prio_num > 1) ? $clog2(prio_num) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BUSY  = 2'd2;

  logic [1:0]     state;
  logic [IW-1:0]  sel_input;
  logic [VW-1:0]  sel_vc;
  logic [PW-1:0]  sel_prio;
  logic [IW-1:0]  rr_ptr [prio_num];

  logic [VCP-1:0]      elig [input_num];
  logic [prio_num-1:0] class_any;
  logic [PW-1:0]       win_p;
  logic                win_found;
  logic [IW-1:0]       win_in;
  logic [VW-1:0]       win_vc;
  logic                req_hold;
  logic [IW-1:0]       next_ptr;

  // A request bit is eligible only when its downstream VC has credit.
  always_comb begin
    for (int i = 0; i < input_num; i++) begin
      elig[i] = i_request[i] & i_credit_ok;
    end
  end

  // Flag every priority class that has at least one eligible request.
  always_comb begin
    class_any = '0;
    for (int p = 0; p < prio_num; p++) begin
      for (int i = 0; i < input_num; i++) begin
        for (int v = 0; v < vc_num; v++) begin
          if (elig[i][VW'(p * vc_num + v)]) begin
            class_any[p] = 1'b1;
          end
        end
      end
    end
  end

  // Strict priority: the highest class with an eligible request wins.
  always_comb begin
    win_p = '0;
    for (int p = 0; p < prio_num; p++) begin
      if (class_any[p]) begin
        win_p = PW'(p);
      end
    end
  end

  // Inside the winning class, scan the inputs starting at the class pointer
  // and wrap around. The first input with any eligible VC wins, and it takes
  // its lowest eligible VC. The VC scan runs downward so that the lowest
  // eligible VC is the one left standing.
  always_comb begin
    int            sum;
    logic [IW-1:0] idx;
    logic [VW-1:0] bidx;
    sum       = 0;
    idx       = '0;
    bidx      = '0;
    win_found = 1'b0;
    win_in    = '0;
    win_vc    = '0;
    for (int k = 0; k < input_num; k++) begin
      sum = int'(rr_ptr[win_p]) + k;
      if (sum >= input_num) begin
        sum = sum - input_num;
      end
      idx = IW'(sum);
      if (!win_found) begin
        for (int v = vc_num - 1; v >= 0; v--) begin
          bidx = VW'(int'(win_p) * vc_num + v);
          if (elig[idx][bidx]) begin
            win_found = 1'b1;
            win_in    = idx;
            win_vc    = bidx;
          end
        end
      end
    end
  end

  // The granted request must still be present in GRANT for the CTS to fire.
  // The pointer advances past the winner and wraps back to input 0.
  always_comb begin
    req_hold = i_request[sel_input][sel_vc];
    next_ptr = (sel_input == IW'(input_num - 1)) ? '0 : sel_input + 1'b1;
  end

  // Scheduler FSM: IDLE picks a winner, GRANT issues CTS, BUSY holds the lock.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      sel_input <= '0;
      sel_vc    <= '0;
      sel_prio  <= '0;
      for (int p = 0; p < prio_num; p++) begin
        rr_ptr[p] <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            sel_input <= win_in;
            sel_vc    <= win_vc;
            sel_prio  <= win_p;
            state     <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (req_hold) begin
            rr_ptr[sel_prio] <= next_ptr;
            state            <= ST_BUSY;
          end else begin
            // The grant was aborted, so fairness state is left untouched.
            state <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (i_valid && i_last) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output decode: CTS only in GRANT, and the one-hot grant while locked.
  always_comb begin
    o_cts   = (state == ST_GRANT) && req_hold;
    o_busy  = (state == ST_BUSY);
    o_grant = '0;
    if (state == ST_GRANT || state == ST_BUSY) begin
      o_grant[sel_input] = 1'b1;
    end
    o_selected_input = sel_input;
    o_selected_vc    = sel_vc;
    o_dbg_state      = state;
  end

endmodule
